// File: rtl/mux2_stream_arbiter.sv
// mux2_stream_arbiter: round-robin packet arbiter driving a 2:1 stream mux.
// The grant is held for a whole packet (until a beat with last transfers).
// Optional per-requester packet counters are enabled with MUX2_ARB_STATS_EN.
module mux2_stream_arbiter #(
    parameter int unsigned DW = 8
`ifdef MUX2_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in0_valid,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_last,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_last,
    output logic          in1_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          sel,
    output logic          busy
`ifdef MUX2_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state, state_n;
    logic   last_gnt, last_gnt_n;
    logic   sel_n;
    logic   rel0, rel1;

    // State, round-robin history and mux select registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            sel      <= 1'b0;
        end else begin
            state    <= state_n;
            last_gnt <= last_gnt_n;
            sel      <= sel_n;
        end
    end

    // Arbitration, packet-grant sequencing and handshake generation
    always_comb begin
        state_n    = state;
        last_gnt_n = last_gnt;
        sel_n      = sel;
        out_valid  = 1'b0;
        in0_ready  = 1'b0;
        in1_ready  = 1'b0;
        rel0       = 1'b0;
        rel1       = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that did not hold the last grant wins
                if (in0_valid && (!in1_valid || last_gnt)) begin
                    state_n = G0;
                    sel_n   = 1'b0;
                end else if (in1_valid) begin
                    state_n = G1;
                    sel_n   = 1'b1;
                end
            end
            G0: begin
                out_valid = in0_valid;
                in0_ready = out_ready;
                if (in0_valid && out_ready && in0_last) begin
                    rel0       = 1'b1;
                    last_gnt_n = 1'b0;
                    if (in1_valid) begin
                        state_n = G1;
                        sel_n   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            G1: begin
                out_valid = in1_valid;
                in1_ready = out_ready;
                if (in1_valid && out_ready && in1_last) begin
                    rel1       = 1'b1;
                    last_gnt_n = 1'b1;
                    if (in0_valid) begin
                        state_n = G0;
                        sel_n   = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath is a plain 2:1 mux on the registered select
    assign out_data = sel ? in1_data : in0_data;
    assign out_last = out_valid & (sel ? in1_last : in0_last);
    assign busy     = (state != IDLE);

`ifdef MUX2_ARB_STATS_EN
    // Saturating count of completed packets per requester
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (rel0 && (pkt_cnt0 != {CNT_W{1'b1}})) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
            if (rel1 && (pkt_cnt1 != {CNT_W{1'b1}})) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Directed bench for mux2_stream_arbiter: expected output beats are queued as
// stimulus is issued and a negedge monitor checks every transferred beat.
module tb_mux2_stream_arbiter;

    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst;
    logic          in0_valid, in0_last, in0_ready;
    logic [DW-1:0] in0_data;
    logic          in1_valid, in1_last, in1_ready;
    logic [DW-1:0] in1_data;
    logic          out_valid, out_last, out_ready;
    logic [DW-1:0] out_data;
    logic          sel, busy;
`ifdef MUX2_ARB_STATS_EN
    logic [1:0]    pkt_cnt0, pkt_cnt1;
`endif

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          s;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    mux2_stream_arbiter #(
        .DW(DW)
`ifdef MUX2_ARB_STATS_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
`ifdef MUX2_ARB_STATS_EN
        , .pkt_cnt0(pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted output beat must match the head of the queue
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got data 0x%0h, want no beat", out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", 32'(out_data), 32'(e.d));
                check("beat_last", 32'(out_last), 32'(e.l));
                check("beat_sel", 32'(sel), 32'(e.s));
            end
        end
    end

    task automatic push(input logic [DW-1:0] d, input logic l, input logic s);
        beat_t b;
        b.d = d;
        b.l = l;
        b.s = s;
        exp_q.push_back(b);
    endtask

    task automatic drive(input logic v0, input logic [DW-1:0] d0, input logic l0,
                         input logic v1, input logic [DW-1:0] d1, input logic l1);
        in0_valid = v0; in0_data = d0; in0_last = l0;
        in1_valid = v1; in1_data = d1; in1_last = l1;
    endtask

    // One clock cycle with the current inputs; control outputs checked mid-cycle
    task automatic cyc(input string nm, input logic eb, input logic es, input logic eov,
                       input logic er0, input logic er1, input logic [DW-1:0] ed);
        @(negedge clk);
        check({nm, "_busy"}, 32'(busy), 32'(eb));
        check({nm, "_sel"}, 32'(sel), 32'(es));
        check({nm, "_out_valid"}, 32'(out_valid), 32'(eov));
        check({nm, "_in0_ready"}, 32'(in0_ready), 32'(er0));
        check({nm, "_in1_ready"}, 32'(in1_ready), 32'(er1));
        if (eov) check({nm, "_out_data"}, 32'(out_data), 32'(ed));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        do_reset();

        // Test 1: single 3-beat packet on in0
        out_ready = 1'b1;
        drive(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0);
        push(8'hA1, 1'b0, 1'b0); push(8'hA2, 1'b0, 1'b0); push(8'hA3, 1'b1, 1'b0);
        cyc("t1_arb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("t1_b1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA1);
        drive(1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc("t1_b2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA2);
        drive(1'b1, 8'hA3, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc("t1_b3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA3);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Test 2: tie after reset, zero-bubble handoff, alternating ties
        do_reset();
        drive(1'b1, 8'hB1, 1'b0, 1'b1, 8'hC1, 1'b0);
        push(8'hB1, 1'b0, 1'b0); push(8'hB2, 1'b1, 1'b0);
        push(8'hC1, 1'b0, 1'b1); push(8'hC2, 1'b1, 1'b1);
        cyc("t2_arb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("t2_b1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB1);
        drive(1'b1, 8'hB2, 1'b1, 1'b1, 8'hC1, 1'b0);
        cyc("t2_b2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB2);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hC1, 1'b0);
        cyc("t2_c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hC2, 1'b1);
        cyc("t2_c2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC2);
        drive(1'b1, 8'hD1, 1'b1, 1'b1, 8'hE1, 1'b1);
        push(8'hD1, 1'b1, 1'b0); push(8'hE1, 1'b1, 1'b1);
        cyc("t2_tie", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("t2_d1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hD1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hE1, 1'b1);
        cyc("t2_e1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hE1);
        drive(1'b1, 8'hF1, 1'b1, 1'b0, 8'h00, 1'b0);
        push(8'hF1, 1'b1, 1'b0);
        cyc("t2_arb_f", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("t2_f1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hF1);

        // Test 3: tie now favours in1; stall 4 cycles mid-packet on G1
        drive(1'b1, 8'h31, 1'b1, 1'b1, 8'h41, 1'b0);
        push(8'h41, 1'b0, 1'b1); push(8'h42, 1'b0, 1'b1); push(8'h43, 1'b1, 1'b1);
        push(8'h31, 1'b1, 1'b0);
        cyc("t3_tie", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("t3_j1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h41);
        drive(1'b1, 8'h31, 1'b1, 1'b1, 8'h42, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("t3_stall", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h42);
        out_ready = 1'b1;
        cyc("t3_j2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h42);
        drive(1'b1, 8'h31, 1'b1, 1'b1, 8'h43, 1'b1);
        cyc("t3_j3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h43);
        drive(1'b1, 8'h31, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc("t3_h1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h31);

        // Test 4: in0 gap mid-packet while in1 waits
        drive(1'b1, 8'h51, 1'b0, 1'b0, 8'h00, 1'b0);
        push(8'h51, 1'b0, 1'b0); push(8'h52, 1'b0, 1'b0); push(8'h53, 1'b1, 1'b0);
        push(8'h61, 1'b1, 1'b1);
        cyc("t4_arb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("t4_m1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h51);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b1);
        for (int i = 0; i < 2; i++) cyc("t4_gap", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 8'h52, 1'b0, 1'b1, 8'h61, 1'b1);
        cyc("t4_m2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h52);
        drive(1'b1, 8'h53, 1'b1, 1'b1, 8'h61, 1'b1);
        cyc("t4_m3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h53);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b1);
        cyc("t4_n1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h61);

        // Test 5: reset during beat 2 of a 4-beat packet, then re-arbitrate
        drive(1'b1, 8'h71, 1'b0, 1'b0, 8'h00, 1'b0);
        push(8'h71, 1'b0, 1'b0);
        cyc("t5_arb", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("t5_p1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h71);
        drive(1'b1, 8'h72, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        cyc("t5_rstcyc", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h72);
        rst = 1'b0;
        drive(1'b1, 8'h91, 1'b1, 1'b1, 8'h92, 1'b1);
        push(8'h91, 1'b1, 1'b0); push(8'h92, 1'b1, 1'b1);
        cyc("t5_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("t5_q1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h91);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h92, 1'b1);
        cyc("t5_r1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h92);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc("t5_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

`ifdef MUX2_ARB_STATS_EN
        // Test 6: saturating packet counter with CNT_W=2
        do_reset();
        check("t6_cnt0_rst", 32'(pkt_cnt0), 32'd0);
        check("t6_cnt1_rst", 32'(pkt_cnt1), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'h20 + i), 1'b1);
            push(8'(8'h20 + i), 1'b1, 1'b1);
            cyc("t6_arb", 1'b0, (i != 0), 1'b0, 1'b0, 1'b0, 8'h00);
            cyc("t6_beat", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'(8'h20 + i));
            check("t6_cnt1", 32'(pkt_cnt1), (i < 3) ? 32'(i + 1) : 32'd3);
            check("t6_cnt0", 32'(pkt_cnt0), 32'd0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
`endif

        cyc("final_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux2_stream_arbiter.md
Name: mux2_stream_arbiter

Overview:
- Round-robin arbiter and sequencer for the team's 2-to-1 multiplexer. It shares one output stream between two packet requesters.
- Owns the mux select and grants the channel one whole packet at a time.
- Provides valid/ready handshakes on both inputs and on the output.
- Sits between two packet sources and a single downstream consumer. Its datapath is exactly the 2:1 mux, with data width DW.

Parameters:
- DW, 8, data width of each input and of the output.
- CNT_W, 16, width of the per-requester packet counters. Used only when MUX2_ARB_STATS_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- in0_valid  input  1  requester 0 has a beat
- in0_data  input  DW  requester 0 data
- in0_last  input  1  marks the final beat of a requester 0 packet
- in0_ready  output  1  requester 0 beat accepted this cycle
- in1_valid  input  1  requester 1 has a beat
- in1_data  input  DW  requester 1 data
- in1_last  input  1  marks the final beat of a requester 1 packet
- in1_ready  output  1  requester 1 beat accepted this cycle
- out_valid  output  1  output beat valid
- out_data  output  DW  muxed data
- out_last  output  1  muxed last
- out_ready  input  1  downstream accepts the beat
- sel  output  1  registered mux select; 0 = in0, 1 = in1
- busy  output  1  a grant is held (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Registers:
  - state ∈ {IDLE=0, G0=1, G1=2}
  - last_gnt (1 bit)
  - sel
- Reset values: state=IDLE, last_gnt=1 (so in0 wins the first tie), sel=0. All outputs are low after reset: out_valid, in0_ready, in1_ready and busy are 0, and out_data/out_last follow sel=0 gated by out_valid=0.
- A beat transfers on a cycle where the selected input's valid and out_ready are both 1.
- IDLE:
  - out_valid=0, in0_ready=0, in1_ready=0.
  - Next state:
    - only in0_valid → G0, sel<=0
    - only in1_valid → G1, sel<=1
    - both valid → the requester != last_gnt
    - neither valid → stay in IDLE; sel holds its value.
- G0 (G1 is symmetric):
  - out_valid=in0_valid, out_data=in0_data, out_last=in0_last.
  - in0_ready=out_ready, in1_ready=0.
- Grant release: on a beat with in0_last=1, set last_gnt<=0. Then:
  - if in1_valid → go to G1, sel<=1 (zero-bubble handoff)
  - else → go to IDLE.
- Grant hold: the grant is held across gaps where in0_valid=0 mid-packet. There is no timeout and no preemption.
- Latency:
  - Arbitration from IDLE takes 1 cycle. A request seen at cycle t can transfer its first beat at t+1 at the earliest.
  - Back-to-back packets from the same requester with the other idle incur 1 bubble cycle (via IDLE).
- Single-beat packet (valid and last on the first beat): the grant is released the same cycle the beat transfers.
- out_ready=0: no transfer, no state change; the data path stays combinational.
- Reset mid-packet: return to the reset values. A partial packet is dropped and upstream must resend it. The downstream sees out_valid=0 from the cycle after rst is sampled.
- Illegal state encoding (3) → IDLE on the next clock.

Optional Feature:
- Macro: MUX2_ARB_STATS_EN.
- When defined, add output ports pkt_cnt0 and pkt_cnt1 (each CNT_W wide).
  - Each counter increments on every transferred last beat of its requester.
  - Each saturates at 2^CNT_W-1 and resets to 0 on rst.
- When undefined, the ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Reset, then in0_valid=1 with a 3-beat packet (0xA1, 0xA2, 0xA3-last), out_ready=1 → busy=1 and sel=0 at t+1. Beats appear on out_data at t+1..t+3, then state returns to IDLE at t+4.
2. Both requesters valid in IDLE immediately after reset → in0 granted first. in1's 2-beat packet follows with zero bubble after in0's last beat. The next tie grants in0 (round-robin alternates).
3. Stall: out_ready=0 for 4 cycles mid-packet on G1 → in1_ready=0, out_data holds, sel=1 and state unchanged. Transfer resumes when out_ready=1.
4. Gap: in0_valid drops for 2 cycles mid-packet while in1_valid=1 → grant stays on G0, in1_ready=0, out_valid=0 during the gap.
5. Assert rst during beat 2 of a 4-beat packet → next cycle state=IDLE, out_valid=0, sel=0. The next request is re-arbitrated with in0 favoured.
6. MUX2_ARB_STATS_EN with CNT_W=2: send 5 single-beat packets on in1 → pkt_cnt1 reads 1, 2, 3, 3, 3; pkt_cnt0 stays 0.
